note_lane_scheduler: RTL

Per-lane note manager for the Guitar Hero display path. Holds up to NOTES falling notes for one fret lane, spawns them on request, advances them down the screen once per video frame, resolves strum hits against a hit window, and answers per-pixel "is this pixel inside a note" queries for the VGA renderer. One instance per lane; the renderer ORs the lanes' `in_note` outputs.

---
 rtl/note_lane_scheduler_pkg.sv | 20 ++
 rtl/note_slot_bounds.sv | 31 +++
 rtl/note_lane_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/note_lane_scheduler_pkg.sv
// Shared definitions for the per-lane note scheduler: FSM encoding,
// screen/note geometry defaults and the slot-index width helper.
package note_lane_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_MOVE        = 2'd1,
    ST_HIT_SCAN    = 2'd2,
    ST_HIT_RESOLVE = 2'd3
  } state_t;

  localparam logic [8:0] SCREEN_H_DEFAULT = 9'd480;
  localparam logic [6:0] NOTE_W_DEFAULT   = 7'd40;

  // Width of an index that can address n slots (never narrower than 1 bit).
  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/note_slot_bounds.sv
// Per-slot pixel comparator: is (curr_x, curr_y) strictly inside this note?
// Sums are formed at 10 bits so a note near the bottom never wraps.
module note_slot_bounds
  import note_lane_scheduler_pkg::*;
#(
  parameter logic [9:0] LANE_X = 10'd100,
  parameter logic [6:0] NOTE_W = NOTE_W_DEFAULT
) (
  input  logic       valid,
  input  logic [8:0] y,
  input  logic [9:0] curr_x,
  input  logic [8:0] curr_y,
  output logic       match
);

  logic [9:0] x_hi;
  logic [9:0] y_lo;
  logic [9:0] y_hi;
  logic [9:0] py;

  // Strict-inequality box test against the note's four edges.
  always_comb begin
    x_hi  = LANE_X + 10'(NOTE_W);
    y_lo  = {1'b0, y};
    y_hi  = {1'b0, y} + 10'(NOTE_W);
    py    = {1'b0, curr_y};
    match = valid && (py > y_lo) && (py < y_hi) &&
            (curr_x > LANE_X) && (curr_x < x_hi);
  end

endmodule

// File: rtl/note_lane_scheduler.sv
// One fret lane: note slots, spawn allocation, per-frame fall, strum hit
// resolution and the registered per-pixel "inside a note" answer.
module note_lane_scheduler
  import note_lane_scheduler_pkg::*;
#(
  parameter int         NOTES    = 8,
  parameter logic [9:0] LANE_X   = 10'd100,
  parameter logic [6:0] NOTE_W   = NOTE_W_DEFAULT,
  parameter logic [3:0] SPEED    = 4'd2,
  parameter logic [8:0] SCREEN_H = SCREEN_H_DEFAULT,
  parameter logic [8:0] HIT_LO   = 9'd400,
  parameter logic [8:0] HIT_HI   = 9'd460
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       frame_tick,
  input  logic                       spawn,
  input  logic                       strum,
  input  logic [9:0]                 curr_x,
  input  logic [8:0]                 curr_y,
  output logic                       in_note,
  output logic                       hit,
  output logic                       strum_miss,
  output logic                       note_miss,
  output logic                       overflow,
  output logic                       busy,
  output logic [$clog2(NOTES):0]     active_count
);

  localparam int             IW   = slot_idx_w(NOTES);
  localparam int             CW   = $clog2(NOTES) + 1;
  localparam logic [IW-1:0]  LAST = IW'(NOTES - 1);

  state_t            state, state_next;
  logic              go_move, go_scan;
  logic [NOTES-1:0]  valid;
  logic [8:0]        ys [NOTES];
  logic [NOTES-1:0]  match;
  logic [IW-1:0]     idx;
  logic              pend_frame, pend_strum;
  logic              cand_found;
  logic [IW-1:0]     cand_idx;
  logic [8:0]        cand_y;

  logic              free_found;
  logic [IW-1:0]     free_idx;
  logic              cur_valid;
  logic [8:0]        cur_y;
  logic [9:0]        y_adv;
  logic              off_screen;
  logic              better;
  logic [CW-1:0]     count;

  for (genvar g = 0; g < NOTES; g++) begin : g_slot
    note_slot_bounds #(.LANE_X(LANE_X), .NOTE_W(NOTE_W)) u_bounds (
      .valid  (valid[g]),
      .y      (ys[g]),
      .curr_x (curr_x),
      .curr_y (curr_y),
      .match  (match[g])
    );
  end

  // Lowest-index free slot, occupancy count and the slot under the scan index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    count      = '0;
    for (int i = NOTES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      count = count + CW'(valid[i]);
    end
    cur_valid  = valid[idx];
    cur_y      = ys[idx];
    y_adv      = {1'b0, cur_y} + {6'd0, SPEED};
    off_screen = (y_adv >= {1'b0, SCREEN_H});
    better     = cur_valid && (cur_y >= HIT_LO) && (cur_y <= HIT_HI) &&
                 (!cand_found || (cur_y > cand_y));
  end

  // Next-state logic; a frame tick (live or pending) beats a strum in IDLE.
  always_comb begin
    state_next = state;
    go_move    = 1'b0;
    go_scan    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_tick || pend_frame) begin
          state_next = ST_MOVE;
          go_move    = 1'b1;
        end else if (strum || pend_strum) begin
          state_next = ST_HIT_SCAN;
          go_scan    = 1'b1;
        end
      end
      ST_MOVE:        if (idx == LAST) state_next = ST_IDLE;
      ST_HIT_SCAN:    if (idx == LAST) state_next = ST_HIT_RESOLVE;
      ST_HIT_RESOLVE: state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Scan index, pending requests and hit-candidate flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idx        <= '0;
      pend_frame <= 1'b0;
      pend_strum <= 1'b0;
      cand_found <= 1'b0;
    end else begin
      if ((state == ST_MOVE) || (state == ST_HIT_SCAN))
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
      else
        idx <= '0;
      if (state == ST_IDLE) begin
        if (go_move) begin
          pend_frame <= 1'b0;
          pend_strum <= pend_strum | strum;
        end else if (go_scan) begin
          pend_strum <= 1'b0;
        end
      end else begin
        pend_frame <= pend_frame | frame_tick;
        pend_strum <= pend_strum | strum;
      end
      if (go_scan)                            cand_found <= 1'b0;
      else if ((state == ST_HIT_SCAN) && better) cand_found <= 1'b1;
    end
  end

  // Candidate location; only meaningful while cand_found is set.
  always_ff @(posedge clock) begin
    if ((state == ST_HIT_SCAN) && better) begin
      cand_idx <= idx;
      cand_y   <= cur_y;
    end
  end

  // Slot storage: fall/expire, hit clear and spawn touch disjoint slots.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      for (int i = 0; i < NOTES; i++) ys[i] <= '0;
    end else begin
      if ((state == ST_MOVE) && cur_valid) begin
        if (off_screen) valid[idx] <= 1'b0;
        else            ys[idx]    <= y_adv[8:0];
      end
      if ((state == ST_HIT_RESOLVE) && cand_found) valid[cand_idx] <= 1'b0;
      if (spawn && free_found) begin
        valid[free_idx] <= 1'b1;
        ys[free_idx]    <= '0;
      end
    end
  end

  // Registered pulses, pixel answer and occupancy count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_note      <= 1'b0;
      hit          <= 1'b0;
      strum_miss   <= 1'b0;
      note_miss    <= 1'b0;
      overflow     <= 1'b0;
      active_count <= '0;
    end else begin
      in_note      <= |match;
      hit          <= (state == ST_HIT_RESOLVE) && cand_found;
      strum_miss   <= (state == ST_HIT_RESOLVE) && !cand_found;
      note_miss    <= (state == ST_MOVE) && cur_valid && off_screen;
      overflow     <= spawn && !free_found;
      active_count <= count;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
